// File: rtl/tinyqv_data_arbiter_if.sv
// Peripheral bus bundle used for both requesters and the downstream port.
// Handshake: a request is live while write_n != 2'b11 or read_n != 2'b11; the master
// holds addr/strobes/wdata stable until the cycle ready is high, and rdata is valid in that cycle.
interface tinyqv_data_arbiter_if;
    logic [27:0] addr;
    logic [1:0]  write_n;
    logic [1:0]  read_n;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output addr, write_n, read_n, wdata, input ready, rdata);
    modport slave  (input addr, write_n, read_n, wdata, output ready, rdata);
endinterface

// File: rtl/tinyqv_data_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between requesters A and B,
// with an idle bubble between transactions and a saturating bus timeout.
module tinyqv_data_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    tinyqv_data_arbiter_if.slave         a,
    tinyqv_data_arbiter_if.slave         b,
    tinyqv_data_arbiter_if.master        ds,
    output logic                         timeout_err,
    output logic                         err_src,
    output logic [1:0]                   state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
    localparam logic [31:0]   ERR_DATA    = 32'hFFFF_FFFF;

    state_t        state, state_nxt;
    logic          last_b, last_b_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_src_nxt;
    logic          a_req, b_req, expire;

    assign a_req     = (a.write_n != 2'b11) || (a.read_n != 2'b11);
    assign b_req     = (b.write_n != 2'b11) || (b.read_n != 2'b11);
    // A ds_ready arriving on the expiry cycle wins over the forced completion.
    assign expire    = (TIMEOUT != 0) && (state != IDLE) && (cnt == TIMEOUT_CNT) && !ds.ready;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_b  <= 1'b1;
            cnt     <= '0;
            err_src <= 1'b0;
        end else begin
            state   <= state_nxt;
            last_b  <= last_b_nxt;
            cnt     <= cnt_nxt;
            err_src <= err_src_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_b_nxt  = last_b;
        cnt_nxt     = cnt;
        err_src_nxt = err_src;
        ds.addr     = a.addr;
        ds.wdata    = a.wdata;
        ds.write_n  = 2'b11;
        ds.read_n   = 2'b11;
        a.ready     = 1'b0;
        b.ready     = 1'b0;
        a.rdata     = '0;
        b.rdata     = '0;
        timeout_err = 1'b0;

        case (state)
            IDLE: begin
                if (a_req && (!b_req || last_b)) begin
                    state_nxt  = GNT_A;
                    last_b_nxt = 1'b0;
                    cnt_nxt    = '0;
                end else if (b_req) begin
                    state_nxt  = GNT_B;
                    last_b_nxt = 1'b1;
                    cnt_nxt    = '0;
                end
            end
            GNT_A: begin
                ds.addr    = a.addr;
                ds.wdata   = a.wdata;
                ds.write_n = a.write_n;
                ds.read_n  = a.read_n;
                a.ready    = ds.ready || expire;
                a.rdata    = expire ? ERR_DATA : ds.rdata;
                if (ds.ready || expire) state_nxt = IDLE;
                if (expire) begin
                    timeout_err = 1'b1;
                    err_src_nxt = 1'b0;
                end
            end
            GNT_B: begin
                ds.addr    = b.addr;
                ds.wdata   = b.wdata;
                ds.write_n = b.write_n;
                ds.read_n  = b.read_n;
                b.ready    = ds.ready || expire;
                b.rdata    = expire ? ERR_DATA : ds.rdata;
                if (ds.ready || expire) state_nxt = IDLE;
                if (expire) begin
                    timeout_err = 1'b1;
                    err_src_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Saturates at TIMEOUT, so the counter can never wrap.
        if ((state != IDLE) && !ds.ready && (TIMEOUT != 0) && (cnt != TIMEOUT_CNT))
            cnt_nxt = cnt + CW'(1);

        if (rst) begin
            ds.write_n  = 2'b11;
            ds.read_n   = 2'b11;
            a.ready     = 1'b0;
            b.ready     = 1'b0;
            timeout_err = 1'b0;
        end
    end
endmodule

// File: tb/tb_tinyqv_data_arbiter.sv
// Bench for tinyqv_data_arbiter: queued requester drivers, a programmable downstream
// responder, a transaction-level model checked every cycle, and a completion scoreboard.
module tb_tinyqv_data_arbiter;
    localparam int TIMEOUT_P = 4;

    typedef struct packed {
        logic [27:0] addr;
        logic [1:0]  wn;
        logic [1:0]  rn;
        logic [31:0] wdata;
    } txn_t;

    logic       clk;
    logic       rst;
    logic       timeout_err;
    logic       err_src;
    logic [1:0] state_dbg;

    tinyqv_data_arbiter_if a_if ();
    tinyqv_data_arbiter_if b_if ();
    tinyqv_data_arbiter_if ds_if ();

    tinyqv_data_arbiter #(.TIMEOUT(TIMEOUT_P), .CW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a_if),
        .b           (b_if),
        .ds          (ds_if),
        .timeout_err (timeout_err),
        .err_src     (err_src),
        .state_dbg   (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // {src (1 = B), rdata} expected for each completion, in order
    logic [32:0] exp_q[$];
    txn_t a_txq[$];
    txn_t b_txq[$];
    txn_t log_q[$];

    logic        a_busy = 0, b_busy = 0, a_done = 0, b_done = 0;
    logic        a_abort = 0;
    int          resp_lat = 1;
    logic [31:0] resp_data = '0;
    logic        stray = 0;
    int          gcnt = 0;
    int          terr_seen = 0;

    // model state
    int   m_owner = 0;   // 0 none, 1 A, 2 B
    int   m_prev  = 2;   // last winner
    int   m_age   = 0;   // grant cycles already elapsed
    logic m_err_src = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic [27:0] addr, input logic [1:0] wn,
                                input logic [1:0] rn, input logic [31:0] wdata);
        txn_t t;
        t.addr = addr; t.wn = wn; t.rn = rn; t.wdata = wdata;
        return t;
    endfunction

    // ---------------- requester drivers ----------------
    always begin : drv_a
        txn_t t;
        @(negedge clk);
        a_done = a_if.ready && !rst;
        @(posedge clk);
        #1;
        if (a_abort || (a_busy && a_done)) a_busy = 0;
        if (!a_busy && a_txq.size() != 0) begin
            t = a_txq.pop_front();
            a_if.addr = t.addr; a_if.write_n = t.wn; a_if.read_n = t.rn; a_if.wdata = t.wdata;
            a_busy = 1;
        end else if (!a_busy) begin
            a_if.addr = 28'($urandom); a_if.write_n = 2'b11; a_if.read_n = 2'b11; a_if.wdata = $urandom;
        end
    end

    always begin : drv_b
        txn_t t;
        @(negedge clk);
        b_done = b_if.ready && !rst;
        @(posedge clk);
        #1;
        if (b_busy && b_done) b_busy = 0;
        if (!b_busy && b_txq.size() != 0) begin
            t = b_txq.pop_front();
            b_if.addr = t.addr; b_if.write_n = t.wn; b_if.read_n = t.rn; b_if.wdata = t.wdata;
            b_busy = 1;
        end else if (!b_busy) begin
            b_if.addr = 28'($urandom); b_if.write_n = 2'b11; b_if.read_n = 2'b11; b_if.wdata = $urandom;
        end
    end

    // ---------------- downstream responder ----------------
    always begin : responder
        @(posedge clk);
        #2;
        if (ds_if.write_n != 2'b11 || ds_if.read_n != 2'b11) begin
            gcnt++;
            if (gcnt == 1) log_q.push_back(mk(ds_if.addr, ds_if.write_n, ds_if.read_n, ds_if.wdata));
            ds_if.ready = (resp_lat != 0) && (gcnt == resp_lat);
            ds_if.rdata = ds_if.ready ? resp_data : $urandom;
        end else begin
            gcnt = 0;
            ds_if.ready = stray;
            ds_if.rdata = $urandom;
        end
    end

    // ---------------- model + compare + scoreboard ----------------
    always @(negedge clk) begin : cmp
        logic        a_req, b_req, to;
        logic [27:0] s_addr;
        logic [1:0]  s_wn, s_rn;
        logic [31:0] s_wdata;
        logic [32:0] e;
        int          win;

        a_req = (a_if.write_n != 2'b11) || (a_if.read_n != 2'b11);
        b_req = (b_if.write_n != 2'b11) || (b_if.read_n != 2'b11);
        to = (m_owner != 0) && (m_age >= TIMEOUT_P) && !ds_if.ready;
        s_addr  = (m_owner == 2) ? b_if.addr    : a_if.addr;
        s_wn    = (m_owner == 2) ? b_if.write_n : a_if.write_n;
        s_rn    = (m_owner == 2) ? b_if.read_n  : a_if.read_n;
        s_wdata = (m_owner == 2) ? b_if.wdata   : a_if.wdata;

        if (rst) begin
            chk("rst_ds_write_n", 32'(ds_if.write_n), 32'h3);
            chk("rst_ds_read_n", 32'(ds_if.read_n), 32'h3);
            chk("rst_a_ready", 32'(a_if.ready), 0);
            chk("rst_b_ready", 32'(b_if.ready), 0);
            chk("rst_timeout_err", 32'(timeout_err), 0);
        end else if (m_owner == 0) begin
            chk("idle_ds_write_n", 32'(ds_if.write_n), 32'h3);
            chk("idle_ds_read_n", 32'(ds_if.read_n), 32'h3);
            chk("idle_a_ready", 32'(a_if.ready), 0);
            chk("idle_b_ready", 32'(b_if.ready), 0);
            chk("idle_a_rdata", a_if.rdata, 0);
            chk("idle_b_rdata", b_if.rdata, 0);
            chk("idle_timeout_err", 32'(timeout_err), 0);
        end else begin
            chk("gnt_ds_addr", 32'(ds_if.addr), 32'(s_addr));
            chk("gnt_ds_write_n", 32'(ds_if.write_n), 32'(s_wn));
            chk("gnt_ds_read_n", 32'(ds_if.read_n), 32'(s_rn));
            chk("gnt_ds_wdata", ds_if.wdata, s_wdata);
            chk("gnt_a_ready", 32'(a_if.ready), (m_owner == 1) ? 32'(ds_if.ready || to) : 0);
            chk("gnt_b_ready", 32'(b_if.ready), (m_owner == 2) ? 32'(ds_if.ready || to) : 0);
            chk("gnt_a_rdata", a_if.rdata, (m_owner == 1) ? (to ? 32'hFFFF_FFFF : ds_if.rdata) : 0);
            chk("gnt_b_rdata", b_if.rdata, (m_owner == 2) ? (to ? 32'hFFFF_FFFF : ds_if.rdata) : 0);
            chk("gnt_timeout_err", 32'(timeout_err), 32'(to));
        end
        chk("err_src", 32'(err_src), 32'(m_err_src));
        if (timeout_err) terr_seen++;

        if (!rst && (a_if.ready || b_if.ready)) begin
            if (exp_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL sb_unexpected: got completion src=%0d expected none at %0t", b_if.ready, $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_src", 32'(b_if.ready), 32'(e[32]));
                chk("sb_rdata", b_if.ready ? b_if.rdata : a_if.rdata, e[31:0]);
            end
        end

        if (rst) begin
            m_owner = 0; m_prev = 2; m_age = 0; m_err_src = 0;
        end else if (m_owner == 0) begin
            win = 0;
            if (a_req && b_req) win = (m_prev == 1) ? 2 : 1;
            else if (a_req)     win = 1;
            else if (b_req)     win = 2;
            if (win != 0) begin
                m_owner = win; m_prev = win; m_age = 0;
            end
        end else if (ds_if.ready || to) begin
            if (to) m_err_src = (m_owner == 2);
            m_owner = 0;
        end else begin
            m_age++;
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((a_txq.size() != 0 || b_txq.size() != 0 || a_busy || b_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("quiet_within_budget", 32'(n < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #3; rst = 1;
        repeat (2) @(posedge clk);
        #3; rst = 0;
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        txn_t l;
        logic [27:0] fair_addr[6];
        int n;
        fair_addr = '{28'h100, 28'h200, 28'h101, 28'h201, 28'h102, 28'h202};

        rst = 1;
        ds_if.ready = 0;
        ds_if.rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ds_read_n", 32'(ds_if.read_n), 32'h3);
        chk("reset_state_idle", 32'(state_dbg), 0);
        chk("reset_err_src", 32'(err_src), 0);
        @(posedge clk); #3; rst = 0;
        @(negedge clk);

        // single A read, ds_ready on the 3rd grant cycle
        resp_lat = 3; resp_data = 32'h1234_5678;
        exp_q.push_back({1'b0, 32'h1234_5678});
        a_txq.push_back(mk(28'h800_0010, 2'b11, 2'b10, 32'h0));
        wait_quiet(100);
        chk("t1_log_size", 32'(log_q.size()), 1);
        l = log_q.pop_front();
        chk("t1_addr", 32'(l.addr), 32'h800_0010);
        chk("t1_read_n", 32'(l.rn), 32'h2);

        // simultaneous first requests after reset: A wins, then B
        do_reset();
        resp_lat = 1; resp_data = 32'h0000_0055;
        exp_q.push_back({1'b0, 32'h0000_0055});
        exp_q.push_back({1'b1, 32'h0000_0055});
        a_txq.push_back(mk(28'h000_0040, 2'b10, 2'b11, 32'hDEAD_BEEF));
        b_txq.push_back(mk(28'h000_0080, 2'b11, 2'b10, 32'h0));
        wait_quiet(100);
        chk("t2_log_size", 32'(log_q.size()), 2);
        l = log_q.pop_front();
        chk("t2_first_write_n", 32'(l.wn), 32'h2);
        chk("t2_first_wdata", l.wdata, 32'hDEAD_BEEF);
        l = log_q.pop_front();
        chk("t2_second_addr", 32'(l.addr), 32'h80);
        chk("t2_second_read_n", 32'(l.rn), 32'h2);

        // fairness: continuous contention alternates A,B,A,B,A,B
        resp_lat = 1; resp_data = 32'h0000_1111;
        for (int i = 0; i < 3; i++) begin
            a_txq.push_back(mk(28'h100 + 28'(i), 2'b11, 2'b10, 32'h0));
            b_txq.push_back(mk(28'h200 + 28'(i), 2'b11, 2'b10, 32'h0));
        end
        for (int i = 0; i < 6; i++) exp_q.push_back({1'(i % 2), 32'h0000_1111});
        wait_quiet(200);
        chk("t3_log_size", 32'(log_q.size()), 6);
        n = log_q.size();
        for (int i = 0; i < n && i < 6; i++) begin
            l = log_q.pop_front();
            chk("t3_grant_order", 32'(l.addr), 32'(fair_addr[i]));
        end
        log_q.delete();

        // timeout on B, then a normal A access
        resp_lat = 0;
        exp_q.push_back({1'b1, 32'hFFFF_FFFF});
        b_txq.push_back(mk(28'h000_0300, 2'b11, 2'b00, 32'h0));
        wait_quiet(100);
        chk("t4_terr_pulses", 32'(terr_seen), 1);
        chk("t4_err_src", 32'(err_src), 1);
        resp_lat = 2; resp_data = 32'h0000_0077;
        exp_q.push_back({1'b0, 32'h0000_0077});
        a_txq.push_back(mk(28'h000_0304, 2'b11, 2'b01, 32'h0));
        wait_quiet(100);
        chk("t4_err_src_held", 32'(err_src), 1);

        // ds_ready on the expiry cycle wins
        resp_lat = 5; resp_data = 32'h0000_00A5;
        exp_q.push_back({1'b0, 32'h0000_00A5});
        a_txq.push_back(mk(28'h000_0308, 2'b11, 2'b10, 32'h0));
        wait_quiet(100);
        chk("t5_no_new_terr", 32'(terr_seen), 1);

        // late/stray ds_ready while idle is ignored
        stray = 1;
        repeat (4) @(negedge clk);
        stray = 0;
        @(negedge clk);

        // reset during the 2nd cycle of GNT_A, then B alone
        resp_lat = 0;
        log_q.delete();
        a_txq.push_back(mk(28'h000_0400, 2'b11, 2'b10, 32'h0));
        n = 0;
        while (gcnt < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_grant_seen", 32'(n < 50), 1);
        @(posedge clk); #3; rst = 1; a_abort = 1;
        @(negedge clk);
        chk("t6_rst_ds_read_n", 32'(ds_if.read_n), 32'h3);
        chk("t6_rst_a_ready", 32'(a_if.ready), 0);
        @(posedge clk); #3; rst = 0; a_abort = 0;
        @(negedge clk);
        chk("t6_state_idle", 32'(state_dbg), 0);
        log_q.delete();
        resp_lat = 1; resp_data = 32'h0000_0B0B;
        exp_q.push_back({1'b1, 32'h0000_0B0B});
        b_txq.push_back(mk(28'h000_0500, 2'b11, 2'b10, 32'h0));
        wait_quiet(100);
        chk("t6_log_size", 32'(log_q.size()), 1);
        l = log_q.pop_front();
        chk("t6_b_addr", 32'(l.addr), 32'h500);

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
